tick_burst_gen: RTL and testbench

- Synthesizable, parametrised successor to the bench-only start/stop clock stimulus.
- Generates a programmable-period, programmable-duty waveform and a one-cycle tick enable from the single system clock.
- Runs either continuously or for a fixed burst of output cycles, with start/stop control and busy/done status.
- Drives seconds/date tick enables in the digital clock, and serves as a reusable stimulus source in benches.

---
 rtl/tick_gen_pkg.sv | 27 ++
 rtl/tick_burst_gen_phase_counter.sv | 40 ++++
 rtl/tick_burst_gen.sv | 117 +++++++++++
 tb/tb_tick_burst_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared types and helpers for the tick/burst waveform generator.
//   state_t      : run-control FSM state (IDLE, RUN)
//   MIN_PERIOD   : smallest legal output period in clk cycles
//   clamp_period : P = max(period, MIN_PERIOD)
//   clamp_high   : H = min(high_time, P-1)
// The helpers work on 32-bit values so that any CNT_W up to 32 can use them.
// Callers cast the result back to their own width.
package tick_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [31:0] MIN_PERIOD = 32'd2;

  function automatic logic [31:0] clamp_period(input logic [31:0] period);
    return (period < MIN_PERIOD) ? MIN_PERIOD : period;
  endfunction

  // p is already clamped, so p - 1 cannot underflow.
  function automatic logic [31:0] clamp_high(input logic [31:0] high_time,
                                             input logic [31:0] p);
    return (high_time > (p - 32'd1)) ? (p - 32'd1) : high_time;
  endfunction

endpackage

// File: rtl/tick_burst_gen_phase_counter.sv
// Phase counter for one output cycle of the tick/burst generator.
// It counts 0 .. term and then wraps back to 0.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   clear      : force phase to 0 (wins over enable)
//   enable     : advance phase by one this cycle
//   term       : terminal phase value (P-1)
//   phase      : current phase
//   wrap       : phase is at the terminal value (last clk of the output cycle)
module phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] phase,
  output logic             wrap
);

  logic [CNT_W-1:0] phase_q;

  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else if (clear) begin
      phase_q <= '0;
    end else if (enable) begin
      if (phase_q == term) phase_q <= '0;
      else                 phase_q <= phase_q + CNT_W'(1);
    end
  end

  assign phase = phase_q;
  assign wrap  = (phase_q == term);

endmodule

// File: rtl/tick_burst_gen.sv
// Programmable-period, programmable-duty waveform and tick generator.
// It runs continuously (burst_len == 0) or for burst_len output cycles.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   start       : request a run (sampled in IDLE only)
//   stop        : abort a run (sampled in any state, wins over start)
//   period      : clk cycles per output cycle (latched on start, min 2)
//   high_time   : clk cycles the wave is high (latched on start, max P-1)
//   burst_len   : output cycles per run, 0 = continuous (latched on start)
//   wave        : duty-cycle waveform
//   tick        : one-cycle pulse in the last clk of each output cycle
//   busy        : run in progress
//   done        : one-cycle pulse after a burst completes without stop
//   cycles_done : output cycles completed in the current or last run
// All outputs decode from state, the latched configuration and the counters.
// No input reaches an output combinationally.
module tick_burst_gen
  import tick_gen_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   high_time,
  input  logic [BURST_W-1:0] burst_len,
  output logic               wave,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] cycles_done
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   p_q, h_q, p_lat, h_lat, term, phase;
  logic [BURST_W-1:0] b_q, cycles_q, cycles_inc;
  logic               in_run, start_ok, wrap, tick_int, last_tick, done_q;

  assign in_run     = (state_q == RUN);
  assign start_ok   = (state_q == IDLE) && start && !stop;
  assign p_lat      = CNT_W'(clamp_period(32'(period)));
  assign h_lat      = CNT_W'(clamp_high(32'(high_time), 32'(p_lat)));
  assign term       = p_q - CNT_W'(1);
  assign tick_int   = in_run && wrap;
  assign cycles_inc = cycles_q + BURST_W'(1);
  // Final tick of a burst: the count reaches B at the edge ending this cycle.
  assign last_tick  = tick_int && (b_q != '0) && (cycles_inc == b_q);

  // The phase is held at 0 throughout IDLE, so the first RUN cycle starts at phase 0.
  phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!in_run),
    .enable (in_run),
    .term   (term),
    .phase  (phase),
    .wrap   (wrap)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  // NOTE: the default assignment first keeps this block free of inferred
  // latches on any path the case does not cover.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_ok)          state_d = RUN;
      RUN:  if (stop || last_tick) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Latched configuration, burst counter and done pulse
  // NOTE: the configuration registers are reset along with the counters.
  // They are few and are rewritten on every start, so resetting them costs
  // little and keeps them out of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q      <= CNT_W'(MIN_PERIOD);
      h_q      <= '0;
      b_q      <= '0;
      cycles_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= last_tick && !stop;
      if (start_ok) begin
        p_q      <= p_lat;
        h_q      <= h_lat;
        b_q      <= burst_len;
        cycles_q <= '0;
      end else if (tick_int && (cycles_q != '1)) begin
        // This increment still happens when stop coincides with a tick.
        // It saturates, which only matters in continuous mode.
        cycles_q <= cycles_inc;
      end
    end
  end

  // Output decode
  always_comb begin
    busy = in_run;
    wave = in_run && (phase < h_q);
    tick = tick_int;
    done = done_q;
  end

  assign cycles_done = cycles_q;

endmodule

// File: tb/tb_tick_burst_gen.sv
// Directed self-checking bench for tick_burst_gen.
// Inputs change 1 time unit after a rising edge.
// Outputs are sampled at that same point, which lies within clk cycle cN.
module tb_tick_burst_gen;

  localparam int CNT_W   = 16;
  localparam int BURST_W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, stop;
  logic [CNT_W-1:0]   period, high_time;
  logic [BURST_W-1:0] burst_len;
  logic               wave, tick, busy, done;
  logic [BURST_W-1:0] cycles_done;

  int n_checks = 0;
  int n_errors = 0;

  tick_burst_gen #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .period      (period),
    .high_time   (high_time),
    .burst_len   (burst_len),
    .wave        (wave),
    .tick        (tick),
    .busy        (busy),
    .done        (done),
    .cycles_done (cycles_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input int exp_cd);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " wave"}, 32'(wave), 0);
    check({tag, " tick"}, 32'(tick), 0);
    check({tag, " cd"},   32'(cycles_done), 32'(exp_cd));
  endtask

  // Start a burst, then check every cycle against the hand-given clamped P/H.
  // Returns after sampling the done cycle.
  task automatic run_burst(input string name, input int per, input int hi, input int bl,
                           input int exp_p, input int exp_h);
    period = CNT_W'(per); high_time = CNT_W'(hi); burst_len = BURST_W'(bl);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= bl * exp_p; k++) begin
      int ph;
      ph = (k - 1) % exp_p;
      check($sformatf("%s c%0d wave", name, k), 32'(wave), 32'(ph < exp_h));
      check($sformatf("%s c%0d tick", name, k), 32'(tick), 32'(ph == exp_p - 1));
      check($sformatf("%s c%0d busy", name, k), 32'(busy), 1);
      check($sformatf("%s c%0d done", name, k), 32'(done), 0);
      check($sformatf("%s c%0d cd", name, k), 32'(cycles_done), 32'((k - 1) / exp_p));
      step();
    end
    check({name, " done pulse"}, 32'(done), 1);
    check_idle({name, " after"}, bl);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    period = '0; high_time = '0; burst_len = '0;
    #3;
    check_idle("in reset", 0);
    check("in reset done", 32'(done), 0);
    #9 rst_n = 1'b1;
    step();
    check_idle("post reset", 0);
    check("post reset done", 32'(done), 0);

    // Basic burst: P=4, H=1, three output cycles.
    run_burst("basic", 4, 1, 3, 4, 1);
    step();
    check("basic done one cycle", 32'(done), 0);
    check("basic cd holds", 32'(cycles_done), 3);

    // Clamping cases.
    run_burst("clamp_p1", 1, 5, 2, 2, 1);
    step();
    run_burst("clamp_h", 4, 9, 2, 4, 3);
    step();
    run_burst("h_zero", 3, 0, 1, 3, 0);
    step();

    // Continuous mode, P=3, stop asserted during c7.
    period = 16'd3; high_time = 16'd1; burst_len = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      check($sformatf("cont c%0d busy", k), 32'(busy), 1);
      check($sformatf("cont c%0d tick", k), 32'(tick), 32'(k % 3 == 0));
      if (k < 7) step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_idle("cont c8", 2);
    check("cont c8 done", 32'(done), 0);
    step();
    check("cont c9 done", 32'(done), 0);

    // start and stop together in IDLE.
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("start+stop busy", 32'(busy), 0);
    step();
    check("start+stop busy later", 32'(busy), 0);

    // start during RUN with a new period is ignored: P stays 4.
    period = 16'd4; high_time = 16'd2; burst_len = 16'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("restart c%0d tick", k), 32'(tick), 32'(k % 4 == 0));
      check($sformatf("restart c%0d wave", k), 32'(wave), 32'(((k - 1) % 4) < 2));
      if (k == 1) begin
        start = 1'b1; period = 16'd2;
      end else begin
        start = 1'b0;
      end
      step();
    end
    check("restart done", 32'(done), 1);
    check("restart cd", 32'(cycles_done), 2);
    step();

    // stop coincident with the final tick: P=2, B=2, final tick in c4.
    period = 16'd2; high_time = 16'd1; burst_len = 16'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("stopfin c4 tick", 32'(tick), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stopfin c5 done", 32'(done), 0);
    check_idle("stopfin c5", 2);
    step();
    check("stopfin c6 done", 32'(done), 0);

    // Asynchronous reset mid-run: P=5, H=3, continuous; reset inside c7.
    period = 16'd5; high_time = 16'd3; burst_len = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 2; k <= 7; k++) step();
    check("rst pre wave", 32'(wave), 1);
    check("rst pre cd", 32'(cycles_done), 1);
    #3 rst_n = 1'b0;
    #1;
    check_idle("rst async", 0);
    check("rst async done", 32'(done), 0);
    #2 rst_n = 1'b1;
    step();
    check_idle("rst released", 0);
    step();
    check("rst still idle", 32'(busy), 0);

    // Back-to-back: start issued in the done cycle.
    run_burst("b2b first", 2, 1, 2, 2, 1);
    period = 16'd3; high_time = 16'd1; burst_len = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("b2b c1 busy", 32'(busy), 1);
    check("b2b c1 wave", 32'(wave), 1);
    check("b2b c1 tick", 32'(tick), 0);
    check("b2b c1 cd", 32'(cycles_done), 0);
    step(); step();
    check("b2b c3 tick", 32'(tick), 1);
    step();
    check("b2b c4 done", 32'(done), 1);
    check("b2b c4 cd", 32'(cycles_done), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
